// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared widths, condition codes, instruction fields and ALU command encodings
package id_stage_pkg;
  localparam int NREG = 15;
  localparam int XLEN = 32;
  localparam int RW = 4;
  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE;
  localparam logic [1:0] M_DP = 2'b00, M_MEM = 2'b01, M_BR = 2'b10;
  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000, OP_CMP = 4'b1010, OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101, OP_MVN = 4'b1111;
  localparam logic [3:0] EX_MOV = 4'b0001, EX_ADD = 4'b0010, EX_ADC = 4'b0011;
  localparam logic [3:0] EX_SUB = 4'b0100, EX_SBC = 4'b0101, EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111, EX_EOR = 4'b1000, EX_MVN = 4'b1001;
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch/writeback inputs and decoded outputs of the decode stage
interface id_stage_if;
  import id_stage_pkg::*;
  logic            freeze;
  logic            flush;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] instruction_in;
  logic [3:0]      sr_flags;
  logic            wb_en;
  logic [RW-1:0]   wb_dest;
  logic [XLEN-1:0] wb_value;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] val_rn;
  logic [XLEN-1:0] val_rm;
  logic [RW-1:0]   dest;
  logic [11:0]     shift_operand;
  logic            imm;
  logic [23:0]     signed_imm_24;
  logic [3:0]      exe_cmd;
  logic            mem_r_en;
  logic            mem_w_en;
  logic            wb_en_out;
  logic            b;
  logic            s;
  logic [RW-1:0]   src1;
  logic [RW-1:0]   src2;
  logic            two_src;
  modport master (
    output freeze, flush, pc_in, instruction_in, sr_flags, wb_en, wb_dest, wb_value,
    input  pc_out, val_rn, val_rm, dest, shift_operand, imm, signed_imm_24, exe_cmd,
           mem_r_en, mem_w_en, wb_en_out, b, s, src1, src2, two_src
  );
  modport slave (
    input  freeze, flush, pc_in, instruction_in, sr_flags, wb_en, wb_dest, wb_value,
    output pc_out, val_rn, val_rm, dest, shift_operand, imm, signed_imm_24, exe_cmd,
           mem_r_en, mem_w_en, wb_en_out, b, s, src1, src2, two_src
  );
endinterface

// File: rtl/id_stage_register_file.sv
// id_stage_register_file: 15x32 register file with write-bypassed reads; index 15 reads the PC
module id_stage_register_file
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_value,
  input  logic [XLEN-1:0] pc,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] regs [NREG];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NREG; i++) regs[i] <= XLEN'(i);
    else if (wb_en && wb_dest != 4'hF) regs[wb_dest] <= wb_value;
  always_comb begin
    rd1 = ra1 == 4'hF ? pc : (wb_en && wb_dest == ra1) ? wb_value : regs[ra1];
    rd2 = ra2 == 4'hF ? pc : (wb_en && wb_dest == ra2) ? wb_value : regs[ra2];
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID latch, register file read, condition check and control decode
module id_stage
  import id_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  logic [XLEN-1:0] instr, pc;
  logic            valid, cond_ok, str, en, n, z, c, v;
  logic [3:0]      cond, opcode;
  logic [1:0]      mode;
  logic            i_bit, s_bit;
  logic [RW-1:0]   rn, rd, rm, ra2;
  ctrl_t           ctl, gated;
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (!bus.freeze) begin
      instr <= bus.instruction_in;
      pc    <= bus.pc_in;
      valid <= 1'b1;
    end
  assign cond   = instr[31:28];
  assign mode   = instr[27:26];
  assign i_bit  = instr[25];
  assign opcode = instr[24:21];
  assign s_bit  = instr[20];
  assign rn     = instr[19:16];
  assign rd     = instr[15:12];
  assign rm     = instr[3:0];
  assign {n, z, c, v} = bus.sr_flags;
  assign str = mode == M_MEM && !s_bit;
  assign ra2 = str ? rd : rm;
  id_stage_register_file u_rf (
    .clk(clk), .rst(rst), .wb_en(bus.wb_en), .wb_dest(bus.wb_dest), .wb_value(bus.wb_value),
    .pc(pc), .ra1(rn), .ra2(ra2), .rd1(bus.val_rn), .rd2(bus.val_rm)
  );
  always_comb begin
    case (cond)
      C_EQ: cond_ok = z;
      C_NE: cond_ok = !z;
      C_CS: cond_ok = c;
      C_CC: cond_ok = !c;
      C_MI: cond_ok = n;
      C_PL: cond_ok = !n;
      C_VS: cond_ok = v;
      C_VC: cond_ok = !v;
      C_HI: cond_ok = c && !z;
      C_LS: cond_ok = !c || z;
      C_GE: cond_ok = n == v;
      C_LT: cond_ok = n != v;
      C_GT: cond_ok = !z && (n == v);
      C_LE: cond_ok = z || (n != v);
      C_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  always_comb begin
    ctl = '0;
    case (mode)
      M_DP: begin
        case (opcode)
          OP_MOV: ctl.exe_cmd = EX_MOV;
          OP_MVN: ctl.exe_cmd = EX_MVN;
          OP_ADD: ctl.exe_cmd = EX_ADD;
          OP_ADC: ctl.exe_cmd = EX_ADC;
          OP_SUB: ctl.exe_cmd = EX_SUB;
          OP_SBC: ctl.exe_cmd = EX_SBC;
          OP_AND: ctl.exe_cmd = EX_AND;
          OP_ORR: ctl.exe_cmd = EX_ORR;
          OP_EOR: ctl.exe_cmd = EX_EOR;
          OP_CMP: ctl.exe_cmd = EX_SUB;
          OP_TST: ctl.exe_cmd = EX_AND;
          default: ctl.exe_cmd = 4'b0000;
        endcase
        ctl.wb_en = ctl.exe_cmd != 4'b0000 && opcode != OP_CMP && opcode != OP_TST;
        ctl.s     = ctl.exe_cmd != 4'b0000 && s_bit;
      end
      M_MEM: begin
        ctl.exe_cmd  = EX_ADD;
        ctl.mem_r_en = s_bit;
        ctl.mem_w_en = !s_bit;
        ctl.wb_en    = s_bit;
      end
      M_BR: ctl.b = 1'b1;
      default: ctl = '0;
    endcase
  end
  assign en    = valid && cond_ok && !bus.freeze;
  assign gated = en ? ctl : '0;
  assign bus.exe_cmd       = gated.exe_cmd;
  assign bus.mem_r_en      = gated.mem_r_en;
  assign bus.mem_w_en      = gated.mem_w_en;
  assign bus.wb_en_out     = gated.wb_en;
  assign bus.b             = gated.b;
  assign bus.s             = gated.s;
  assign bus.pc_out        = pc;
  assign bus.dest          = rd;
  assign bus.shift_operand = instr[11:0];
  assign bus.imm           = i_bit;
  assign bus.signed_imm_24 = instr[23:0];
  assign bus.src1          = rn;
  assign bus.src2          = ra2;
  assign bus.two_src       = (!i_bit && mode == M_DP) || str;
endmodule
